cmp_check_pipe: RTL and testbench
=================================

Name: cmp_check_pipe

Overview:
- Parametrised, pipelined relational comparator with valid/ready streaming on both sides.
- Generalises a single continuous `<=` to six ops, signed/unsigned mode, configurable width and pipeline depth.
- Adds an in-line checker that compares each result against an expected value and keeps pass/error statistics.
- Sits between stimulus generators and scoreboards in self-checking regression benches; also usable as a datapath compare unit.

Parameters:
- WIDTH, 32, operand width in bits (>=1).
- STAGES, 2, pipeline depth = input-to-output latency in cycles (1..4).
- CNT_W, 16, width of pass/error counters.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_a  input  WIDTH  left operand.
- in_b  input  WIDTH  right operand.
- in_op  input  3  0 LT, 1 LE, 2 GT, 3 GE, 4 EQ, 5 NE, 6/7 illegal.
- in_signed  input  1  1 = two's-complement compare, 0 = unsigned.
- in_chk  input  1  check this beat against in_exp.
- in_exp  input  1  expected result.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- out_res  output  1  compare result.
- out_err  output  1  this beat failed its check, or had an illegal op.
- clr  input  1  synchronous clear of counters and sticky flag.
- err_sticky  output  1  set on any error beat; held until clr or reset.
- pass_cnt  output  CNT_W  checked beats that matched.
- err_cnt  output  CNT_W  error beats.

Behaviour:
- Reset, asynchronous on rst_n low:
  - All stage valids are 0, so out_valid = 0.
  - out_res, out_err, err_sticky = 0; pass_cnt = err_cnt = 0.
  - in_ready = 1 one cycle after rst_n rises.
  - Reset mid-operation discards all in-flight beats with no partial output.
- Compare logic sits in stage 1 and is registered; later stages only carry the result.
  - With in_signed = 1, the MSB is the sign bit; otherwise the compare is unsigned.
  - Results are full-width; there is no truncation or overflow.
- Illegal op: out_res = 0 and out_err = 1, regardless of in_chk.
- Check: out_err = in_chk & (res != in_exp). When in_chk = 0, out_err is 0 for legal ops.
- Pipeline:
  - STAGES registers, each with its own valid bit.
  - Stage k loads when it is empty or stage k+1 is loading (bubble-collapsing).
  - The last stage drains on out_valid & out_ready.
  - in_ready = !v[1] | stage 1 loading. This is combinational from out_ready through the chain; no skid buffer.
  - Latency with no backpressure is exactly STAGES cycles; full throughput is 1 beat per cycle.
  - Under stall, out_* stay stable while out_valid = 1 and !out_ready.
- Counters and sticky flag update only on output handshakes:
  - pass_cnt increments on a handshake with chk & !err.
  - err_cnt increments on a handshake with out_err.
  - Both saturate at all-ones and never wrap.
  - err_sticky sets on any out_err handshake.
  - clr in the same cycle as a handshake: clr wins, and that beat is not counted.
- STAGES outside 1..4 is an elaboration error via a generate-time $error.

Optional Feature:
- Macro: CMP_XCHECK_EN, simulation only.
- When defined:
  - Any X/Z bit in in_a, in_b, in_op or in_signed of an accepted beat forces out_res = 1'bx and out_err = 1.
  - That beat also increments err_cnt.
  - A $display with operand values is issued.
- When undefined: 2-state semantics, with no X detection logic.

Decomposition:
- Package cmp_pkg holds:
  - the op enum (CMP_LT..CMP_NE) and the legality function;
  - the pure compare function compare(a, b, op, signed_mode).
- One natural sub-module, cmp_pipe_stage: a valid/data register with load/drain control, instantiated STAGES times.
- Counters stay in the top level.

Test Plan:
- LE, unsigned, chk=1, STAGES=2, out_ready=1:
  - (0,0,exp 1) -> res 1.
  - (1,0,exp 0) -> res 0.
  - (1,1,exp 1) -> res 1.
  - (1001,1002,exp 1) -> res 1.
  - (1003,1002,exp 0) -> res 0.
  - Each appears exactly 2 cycles after acceptance; pass_cnt = 5, err_cnt = 0.
- Signed vs unsigned, a=32'hFFFF_FFFF, b=1, op LT:
  - in_signed=1 -> res 1.
  - in_signed=0 -> res 0.
  - Sweep all six ops on a=b=5 -> res 0,1,0,1,1,0.
- Backpressure:
  - Stream 8 beats while out_ready toggles 1,0,0,1,…
  - Outputs appear in order with none lost or duplicated; out_* are stable while stalled.
  - in_ready drops only once all stages are full.
- Errors:
  - exp deliberately wrong on beat 3 -> out_err=1, err_sticky=1, err_cnt=1.
  - op=6 -> res 0, err_cnt=2.
  - clr -> counters 0, sticky 0.
  - clr coincident with a handshake -> that beat is uncounted.
- Saturation and reset: CNT_W=4.
  - 20 passing beats -> pass_cnt = 15, held.
  - rst_n low with 2 beats in flight -> out_valid = 0 immediately, no outputs after release.
- With CMP_XCHECK_EN: a = 'x -> res 1'bx, out_err=1, err_cnt increments.

Source files
------------

// File: rtl/cmp_check_pipe_pkg.sv
// Shared types and pure compare helpers for the cmp_check_pipe comparator.
package cmp_pkg;

    localparam int unsigned CMP_MAX_W = 128;

    typedef enum logic [2:0] {
        CMP_LT = 3'd0,
        CMP_LE = 3'd1,
        CMP_GT = 3'd2,
        CMP_GE = 3'd3,
        CMP_EQ = 3'd4,
        CMP_NE = 3'd5
    } cmp_op_e;

    typedef struct packed {
        logic chk;
        logic res;
        logic err;
    } cmp_beat_t;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= 3'd5;
    endfunction

    // Operands arrive pre-extended to CMP_MAX_W in the same mode as signed_mode.
    function automatic logic compare(input logic [CMP_MAX_W-1:0] a,
                                     input logic [CMP_MAX_W-1:0] b,
                                     input logic [2:0]           op,
                                     input logic                 signed_mode);
        logic lt;
        logic eq;
        logic r;
        eq = (a == b);
        lt = signed_mode ? ($signed(a) < $signed(b)) : (a < b);
        r  = 1'b0;
        case (cmp_op_e'(op))
            CMP_LT:  r = lt;
            CMP_LE:  r = lt | eq;
            CMP_GT:  r = ~lt & ~eq;
            CMP_GE:  r = ~lt;
            CMP_EQ:  r = eq;
            CMP_NE:  r = ~eq;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cmp_check_pipe_if.sv
// Valid/ready stream bundle for cmp_check_pipe: operand beat in, result beat out.
interface cmp_check_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             in_signed;
    logic             in_chk;
    logic             in_exp;
    logic             out_valid;
    logic             out_ready;
    logic             out_res;
    logic             out_err;

    modport master (
        output in_valid, in_a, in_b, in_op, in_signed, in_chk, in_exp, out_ready,
        input  in_ready, out_valid, out_res, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_signed, in_chk, in_exp, out_ready,
        output in_ready, out_valid, out_res, out_err
    );
endinterface

// File: rtl/cmp_check_pipe_stage.sv
// One pipeline slot of cmp_check_pipe: valid bit plus result payload.
module cmp_pipe_stage
    import cmp_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      load_i,
    input  logic      valid_i,
    input  cmp_beat_t data_i,
    output logic      valid_o,
    output cmp_beat_t data_o
);
    logic      valid_q;
    cmp_beat_t data_q;

    // Payload only moves with a real beat so a stalled output stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= valid_i;
            if (valid_i) data_q <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/cmp_check_pipe.sv
// Pipelined relational comparator with in-line result checker and pass/error statistics.
// Optional simulation-only X detection on accepted beats: define CMP_XCHECK_EN.
module cmp_check_pipe
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    cmp_check_pipe_if.slave  bus,
    input  logic             clr,
    output logic             err_sticky,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("cmp_check_pipe: STAGES must be in 1..4");
    end
    if (WIDTH < 1 || WIDTH > CMP_MAX_W) begin : g_bad_width
        $error("cmp_check_pipe: WIDTH out of range");
    end

    logic [CMP_MAX_W-1:0] a_ext;
    logic [CMP_MAX_W-1:0] b_ext;
    cmp_beat_t            beat_in;
`ifdef CMP_XCHECK_EN
    logic                 x_bad;
    assign x_bad = $isunknown({bus.in_a, bus.in_b, bus.in_op, bus.in_signed});
`endif

    always_comb begin
        a_ext = bus.in_signed ? CMP_MAX_W'($signed(bus.in_a)) : CMP_MAX_W'(bus.in_a);
        b_ext = bus.in_signed ? CMP_MAX_W'($signed(bus.in_b)) : CMP_MAX_W'(bus.in_b);
    end

    always_comb begin
        beat_in     = '0;
        beat_in.chk = bus.in_chk;
        if (!op_legal(bus.in_op)) begin
            beat_in.res = 1'b0;
            beat_in.err = 1'b1;
        end else begin
            beat_in.res = compare(a_ext, b_ext, bus.in_op, bus.in_signed);
            beat_in.err = bus.in_chk & (beat_in.res != bus.in_exp);
        end
`ifdef CMP_XCHECK_EN
        if (x_bad) begin
            beat_in.res = 1'bx;
            beat_in.err = 1'b1;
        end
`endif
    end

`ifdef CMP_XCHECK_EN
    always_ff @(posedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready && x_bad)
            $display("cmp_check_pipe: X/Z on accepted beat a=%h b=%h op=%b signed=%b",
                     bus.in_a, bus.in_b, bus.in_op, bus.in_signed);
    end
`endif

    logic [STAGES:1] stg_v;
    logic [STAGES:1] stg_load;
    cmp_beat_t       stg_d [1:STAGES];

    // A stage loads if it is empty or the stage after it is loading.
    always_comb begin
        logic ld;
        ld       = bus.out_ready;
        stg_load = '0;
        for (int unsigned k = STAGES; k >= 1; k--) begin
            stg_load[k] = ~stg_v[k] | ld;
            ld          = stg_load[k];
        end
    end

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        logic      prev_v;
        cmp_beat_t prev_d;
        if (k == 1) begin : g_first
            assign prev_v = bus.in_valid;
            assign prev_d = beat_in;
        end else begin : g_chain
            assign prev_v = stg_v[k-1];
            assign prev_d = stg_d[k-1];
        end
        cmp_pipe_stage u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (stg_load[k]),
            .valid_i (prev_v),
            .data_i  (prev_d),
            .valid_o (stg_v[k]),
            .data_o  (stg_d[k])
        );
    end

    cmp_beat_t out_beat;
    logic      hs;

    assign out_beat      = stg_d[STAGES];
    assign bus.in_ready  = stg_load[1];
    assign bus.out_valid = stg_v[STAGES];
    assign bus.out_res   = out_beat.res;
    assign bus.out_err   = out_beat.err;
    assign hs            = stg_v[STAGES] & bus.out_ready;

    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] errc_q, errc_d;
    logic             sticky_q, sticky_d;

    always_comb begin
        pass_d   = pass_q;
        errc_d   = errc_q;
        sticky_d = sticky_q;
        if (clr) begin
            pass_d   = '0;
            errc_d   = '0;
            sticky_d = 1'b0;
        end else if (hs) begin
            if (out_beat.err) begin
                sticky_d = 1'b1;
                if (errc_q != '1) errc_d = errc_q + CNT_W'(1);
            end else if (out_beat.chk && pass_q != '1) begin
                pass_d = pass_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q   <= '0;
            errc_q   <= '0;
            sticky_q <= 1'b0;
        end else begin
            pass_q   <= pass_d;
            errc_q   <= errc_d;
            sticky_q <= sticky_d;
        end
    end

    assign pass_cnt   = pass_q;
    assign err_cnt    = errc_q;
    assign err_sticky = sticky_q;
endmodule

// File: tb/tb_cmp_check_pipe.sv
// Scoreboard bench for cmp_check_pipe (STAGES=2, CNT_W=4, WIDTH=32).
module tb_cmp_check_pipe;
    localparam int unsigned STAGES  = 2;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MAX = 15;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic             err_sticky;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] err_cnt;

    cmp_check_pipe_if #(.WIDTH(32)) bus ();

    cmp_check_pipe #(.WIDTH(32), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .clr        (clr),
        .err_sticky (err_sticky),
        .pass_cnt   (pass_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic model_res(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] op, input logic sgn);
        logic lt;
        lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
        case (op)
            3'd0:    return lt;
            3'd1:    return lt || (a == b);
            3'd2:    return !lt && (a != b);
            3'd3:    return !lt;
            3'd4:    return a == b;
            3'd5:    return a != b;
            default: return 1'b0;
        endcase
    endfunction

    typedef struct {
        logic        res;
        logic        err;
        logic        chk;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    logic        accepted = 1'b0;
    logic        lat_mode = 1'b0;
    logic        bp_mode = 1'b0;
    int unsigned bp_idx = 0;
    int unsigned m_pass = 0;
    int unsigned m_err = 0;
    logic        m_sticky = 1'b0;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            bus.out_ready = (bp_idx % 3 == 0);
            bp_idx++;
        end
    end

    // Output compare, in_ready model and acceptance capture, all mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        logic hs;
        accepted = 1'b0;
        hs       = 1'b0;
        if (rst_n) begin
            check("in_ready", 32'(bus.in_ready), 32'((sb.size() < STAGES) || bus.out_ready));
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 32'(bus.out_valid), 32'd0);
                end else begin
                    check("out_res", 32'(bus.out_res), 32'(sb[0].res));
                    check("out_err", 32'(bus.out_err), 32'(sb[0].err));
                    if (bus.out_ready) begin
                        hs = 1'b1;
                        e  = sb.pop_front();
                        if (lat_mode) check("latency", cyc - e.cyc, STAGES);
                    end
                end
            end
            if (clr) begin
                m_pass   = 0;
                m_err    = 0;
                m_sticky = 1'b0;
            end else if (hs) begin
                if (e.err) begin
                    m_sticky = 1'b1;
                    if (m_err != CNT_MAX) m_err++;
                end else if (e.chk && m_pass != CNT_MAX) begin
                    m_pass++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_t n;
                n.chk = bus.in_chk;
                n.cyc = cyc;
                n.res = model_res(bus.in_a, bus.in_b, bus.in_op, bus.in_signed);
                n.err = (bus.in_op > 3'd5) || (bus.in_chk && (n.res != bus.in_exp));
`ifdef CMP_XCHECK_EN
                if ($isunknown({bus.in_a, bus.in_b, bus.in_op, bus.in_signed})) begin
                    n.res = 1'bx;
                    n.err = 1'b1;
                end
`endif
                sb.push_back(n);
                accepted = 1'b1;
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic sgn, input logic chk, input logic exp);
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_op     = op;
        bus.in_signed = sgn;
        bus.in_chk    = chk;
        bus.in_exp    = exp;
        bus.in_valid  = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk); #1;
            if (accepted) begin
                @(posedge clk); #1;
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check("send_timeout", 32'(accepted), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && sb.size() != 0; t++) @(posedge clk);
        check("drain", sb.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_pass"}, 32'(pass_cnt), m_pass);
        check({tag, "_err"}, 32'(err_cnt), m_err);
        check({tag, "_sticky"}, 32'(err_sticky), 32'(m_sticky));
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        sgn;
        logic        sweep_exp [6];
        sweep_exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = '0;
        bus.in_signed = 1'b0;
        bus.in_chk    = 1'b0;
        bus.in_exp    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_res", 32'(bus.out_res), 32'd0);
        check("rst_out_err", 32'(bus.out_err), 32'd0);
        check("rst_sticky", 32'(err_sticky), 32'd0);
        check("rst_pass", 32'(pass_cnt), 32'd0);
        check("rst_err", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        lat_mode = 1'b1;
        send(32'd0, 32'd0, 3'd1, 1'b0, 1'b1, 1'b1);
        send(32'd1, 32'd0, 3'd1, 1'b0, 1'b1, 1'b0);
        send(32'd1, 32'd1, 3'd1, 1'b0, 1'b1, 1'b1);
        send(32'd1001, 32'd1002, 3'd1, 1'b0, 1'b1, 1'b1);
        send(32'd1003, 32'd1002, 3'd1, 1'b0, 1'b1, 1'b0);
        drain();
        check("le_pass", 32'(pass_cnt), 32'd5);
        check("le_err", 32'(err_cnt), 32'd0);

        send(32'hFFFF_FFFF, 32'd1, 3'd0, 1'b1, 1'b1, 1'b1);
        send(32'hFFFF_FFFF, 32'd1, 3'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) send(32'd5, 32'd5, 3'(i), 1'b0, 1'b1, sweep_exp[i]);
        drain();
        check("sweep_pass", 32'(pass_cnt), 32'd13);
        check_counters("sweep");

        lat_mode = 1'b0;
        bp_idx   = 0;
        bp_mode  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a   = $urandom_range(0, 15);
            b   = $urandom_range(0, 15);
            op  = 3'($urandom_range(0, 5));
            sgn = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) a = ~a;
            send(a, b, op, sgn, 1'b1, model_res(a, b, op, sgn));
        end
        drain();
        bp_mode = 1'b0;
        bus.out_ready = 1'b1;
        check_counters("bp");

        pulse_clr();
        check("clr1_pass", 32'(pass_cnt), 32'd0);
        lat_mode = 1'b1;
        send(32'd3, 32'd4, 3'd0, 1'b0, 1'b1, 1'b1);
        send(32'd4, 32'd4, 3'd4, 1'b0, 1'b1, 1'b1);
        send(32'd9, 32'd2, 3'd2, 1'b0, 1'b1, 1'b0);
        send(32'd7, 32'd7, 3'd5, 1'b0, 1'b1, 1'b0);
        send(32'd1, 32'd2, 3'd3, 1'b0, 1'b1, 1'b0);
        drain();
        check("err1_cnt", 32'(err_cnt), 32'd1);
        check("err1_sticky", 32'(err_sticky), 32'd1);
        check("err1_pass", 32'(pass_cnt), 32'd4);
        send(32'd2, 32'd1, 3'd6, 1'b0, 1'b0, 1'b0);
        drain();
        check("illegal_err", 32'(err_cnt), 32'd2);
        check_counters("illegal");
        pulse_clr();
        check("clr2_pass", 32'(pass_cnt), 32'd0);
        check("clr2_err", 32'(err_cnt), 32'd0);
        check("clr2_sticky", 32'(err_sticky), 32'd0);

        lat_mode = 1'b0;
        bus.out_ready = 1'b0;
        send(32'd8, 32'd9, 3'd0, 1'b0, 1'b1, 1'b1);
        for (int t = 0; t < 50 && !bus.out_valid; t++) begin
            @(posedge clk); #1;
        end
        check("clr_hs_wait", 32'(bus.out_valid), 32'd1);
        clr = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_hs_pass", 32'(pass_cnt), 32'd0);
        check("clr_hs_drain", sb.size(), 32'd0);

        lat_mode = 1'b1;
        for (int i = 0; i < 20; i++) send(32'(i), 32'(i + 1), 3'd0, 1'b0, 1'b1, 1'b1);
        drain();
        check("sat_pass", 32'(pass_cnt), 32'd15);
        check_counters("sat");

        send(32'd1, 32'd2, 3'd0, 1'b0, 1'b1, 1'b1);
        send(32'd3, 32'd4, 3'd0, 1'b0, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        sb.delete();
        m_pass   = 0;
        m_err    = 0;
        m_sticky = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_pass", 32'(pass_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("postrst_out_valid", 32'(bus.out_valid), 32'd0);
        check_counters("postrst");

`ifdef CMP_XCHECK_EN
        send(32'bx, 32'd1, 3'd0, 1'b0, 1'b0, 1'b0);
        drain();
        check("xchk_err", 32'(err_cnt), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
